exec_sequencer: RTL and testbench

Execute-stage controller between decode and the core's writeback. It accepts one operation at a time over a valid/ready handshake. Non-divide operations go to the single-cycle `alu` through its `enabled`/`completed` pair. RV32M divide and remainder operations run on an internal 32-iteration restoring divider, because the combinational divide path in the ALU is not timing-closable. Results are returned over a valid/ready response port with a registered result and a one-deep holding register.

---
 rtl/exec_sequencer.sv | 168 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: ALU ops go out through the single-cycle ALU
// handshake, and RV32M divide/remainder ops run on an internal 32-step
// restoring divider. Results are held in a registered response slot.
module exec_sequencer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        alu_enabled,
  input  logic        alu_completed,
  input  logic [31:0] alu_result,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ALU_WAIT = 3'd1,
    DIV_RUN  = 3'd2,
    DIV_FIX  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state, state_n;

  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic        q_sign;
  logic        r_sign;
  logic        is_rem;

  logic        accept;
  logic        is_div_op;
  logic        op_signed;
  logic        div_zero;
  logic        div_ovf;
  logic        special;
  logic [31:0] special_value;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [33:0] shifted;
  logic [33:0] trial;
  logic [31:0] fix_value;

  // Handshake, request decode and divider datapath terms
  always_comb begin
    req_ready     = rstn & (state == IDLE) & ~flush;
    accept        = req_valid & req_ready;
    is_div_op     = req_op[2];
    alu_enabled   = accept & ~is_div_op;
    op_signed     = ~req_op[0];
    div_zero      = (req_rs2 == 32'd0);
    div_ovf       = op_signed & (req_rs1 == 32'h8000_0000) & (req_rs2 == 32'hFFFF_FFFF);
    special       = div_zero | div_ovf;
    special_value = 32'd0;
    if (div_zero) begin
      special_value = req_op[1] ? req_rs1 : 32'hFFFF_FFFF;
    end else begin
      special_value = req_op[1] ? 32'd0 : 32'h8000_0000;
    end
    mag_a         = (op_signed & req_rs1[31]) ? (32'd0 - req_rs1) : req_rs1;
    mag_b         = (op_signed & req_rs2[31]) ? (32'd0 - req_rs2) : req_rs2;
    shifted       = {rem, quo[31]};
    trial         = shifted - {2'b00, dvs};
    fix_value     = is_rem ? (r_sign ? (32'd0 - rem[31:0]) : rem[31:0])
                           : (q_sign ? (32'd0 - quo) : quo);
    resp_valid    = (state == DONE);
    busy          = (state != IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state selection; flush overrides every transition
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_div_op) begin
              state_n = ALU_WAIT;
            end else if (special) begin
              state_n = DONE;
            end else begin
              state_n = DIV_RUN;
            end
          end
        end
        ALU_WAIT: if (alu_completed) state_n = DONE;
        DIV_RUN:  if (cnt == 5'd0) state_n = DIV_FIX;
        DIV_FIX:  state_n = DONE;
        DONE:     if (resp_ready) state_n = IDLE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // Divider registers and the held response value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_result <= 32'd0;
      rem         <= 33'd0;
      quo         <= 32'd0;
      dvs         <= 32'd0;
      cnt         <= 5'd0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      is_rem      <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (accept && is_div_op) begin
            if (special) begin
              resp_result <= special_value;
            end else begin
              quo    <= mag_a;
              dvs    <= mag_b;
              rem    <= 33'd0;
              cnt    <= 5'd31;
              q_sign <= op_signed & (req_rs1[31] ^ req_rs2[31]);
              r_sign <= op_signed & req_rs1[31];
              is_rem <= req_op[1];
            end
          end
        end
        ALU_WAIT: begin
          if (alu_completed) begin
            resp_result <= alu_result;
          end
        end
        DIV_RUN: begin
          if (!trial[33]) begin
            rem <= trial[32:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shifted[32:0];
            quo <= {quo[30:0], 1'b0};
          end
          if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV_FIX: begin
          resp_result <= fix_value;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed vector table, hand-written
// flush/reset/backpressure sequences, and randomized ops against a model.
module tb_exec_sequencer;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        alu_enabled;
  logic        alu_completed;
  logic [31:0] alu_result;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  int total;
  int bad;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] aluv;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  exec_sequencer dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .alu_enabled   (alu_enabled),
    .alu_completed (alu_completed),
    .alu_result    (alu_result),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected result straight from the RV32M definitions
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] aluv);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    if (op < 3'd4) return aluv;
    if (b == 32'd0) return (op == 3'd4 || op == 3'd5) ? 32'hFFFF_FFFF : a;
    case (op)
      3'd4: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return a / b;
      3'd6: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1;
    if (b == 32'd0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op from IDLE (called at a falling edge), measure latency, collect the result
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] aluv, input bit rand_ready,
                                output logic [31:0] res, output int lat, output bit timed_out);
    int   n;
    int   guard;
    bit   got;
    logic [31:0] held;
    res       = 32'd0;
    lat       = -1;
    timed_out = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    resp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    check_output("req_ready_idle", {31'd0, req_ready}, 32'd1);
    check_output("alu_enabled_issue", {31'd0, alu_enabled}, {31'd0, (op < 3'd4)});
    @(posedge clk);
    @(negedge clk);
    #1;
    check_output("alu_enabled_one_cycle", {31'd0, alu_enabled}, 32'd0);
    req_valid = 1'b0;
    if (op < 3'd4) begin
      alu_completed = 1'b1;
      alu_result    = aluv;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n <= 60) begin
      if (resp_valid) begin
        got = 1'b1;
        lat = n;
      end else begin
        @(posedge clk);
        n++;
        @(negedge clk);
        alu_completed = 1'b0;
        alu_result    = $urandom;
        if (rand_ready) resp_ready = 1'($urandom_range(0, 1));
      end
    end
    alu_completed = 1'b0;
    if (!got) begin
      timed_out = 1'b1;
      resp_ready = 1'b1;
      return;
    end
    res   = resp_result;
    held  = res;
    guard = 0;
    while (!resp_ready) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
      check_output("hold_valid", {31'd0, resp_valid}, 32'd1);
      check_output("hold_result", resp_result, held);
      resp_ready = (guard > 8) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    @(negedge clk);
    check_output("single_response", {31'd0, resp_valid}, 32'd0);
    resp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] aluv;
    logic [2:0]  op;
    int          lat;
    int          n;
    bit          to;
    bit          seen;

    total = 0;
    bad   = 0;

    vecs[0]  = '{3'd0, 32'h0,         32'h0,         32'h1234_5678, 32'h1234_5678, 1};
    vecs[1]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'h0,         32'hFFFF_FFFD, 33};
    vecs[2]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'h0,         32'hFFFF_FFFF, 33};
    vecs[3]  = '{3'd5, 32'hFFFF_FFFF, 32'd16,        32'h0,         32'h0FFF_FFFF, 33};
    vecs[4]  = '{3'd7, 32'd100,       32'd7,         32'h0,         32'd2,         33};
    vecs[5]  = '{3'd4, 32'd5,         32'd0,         32'h0,         32'hFFFF_FFFF, 0};
    vecs[6]  = '{3'd7, 32'd5,         32'd0,         32'h0,         32'd5,         0};
    vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0};
    vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'd0,         0};
    vecs[9]  = '{3'd2, 32'd1,         32'd0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
    vecs[10] = '{3'd5, 32'd9,         32'd3,         32'h0,         32'd3,         33};
    vecs[11] = '{3'd4, 32'h8000_0000, 32'd2,         32'h0,         32'hC000_0000, 33};
    vecs[12] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'h0,         32'hFFFF_FFFD, 33};
    vecs[13] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0,         32'd1,         33};
    vecs[14] = '{3'd4, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         32'd0,         33};
    vecs[15] = '{3'd6, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         32'h7FFF_FFFF, 33};

    rstn          = 1'b0;
    req_valid     = 1'b1;
    req_op        = 3'd0;
    req_rs1       = 32'd0;
    req_rs2       = 32'd0;
    alu_completed = 1'b0;
    alu_result    = 32'd0;
    flush         = 1'b0;
    resp_ready    = 1'b1;
    #1;
    check_output("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check_output("reset_alu_enabled", {31'd0, alu_enabled}, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_output("reset_resp_result", resp_result, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] directed vectors");
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].aluv, 1'b0, res, lat, to);
      check_output("vec_timeout", {31'd0, to}, 32'd0);
      check_output($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    $display("[TB] backpressure");
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_rs1   = 32'hFFFF_FF9C;
    req_rs2   = 32'd7;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check_output("bp_latency", 32'(n), 32'd33);
    req_valid = 1'b1;
    req_op    = 3'd0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_output("bp_valid", {31'd0, resp_valid}, 32'd1);
      check_output("bp_result", resp_result, 32'hFFFF_FFF2);
      check_output("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_output("bp_after_hs_valid", {31'd0, resp_valid}, 32'd0);
    check_output("bp_after_hs_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid     = 1'b0;
    alu_completed = 1'b1;
    alu_result    = 32'h0000_0055;
    check_output("bp_next_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    alu_completed = 1'b0;
    check_output("bp_next_result", resp_result, 32'h0000_0055);
    check_output("bp_next_valid", {31'd0, resp_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);

    $display("[TB] flush mid-divide");
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_rs1   = 32'd1000;
    req_rs2   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_output("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    #1;
    check_output("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_output("flush_busy_after", {31'd0, busy}, 32'd0);
    check_output("flush_valid_after", {31'd0, resp_valid}, 32'd0);
    check_output("flush_ready_after", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check_output("flush_no_response", {31'd0, seen}, 32'd0);

    $display("[TB] flush priority over acceptance");
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'd0;
    #1;
    check_output("flush_idle_ready", {31'd0, req_ready}, 32'd0);
    check_output("flush_idle_alu_en", {31'd0, alu_enabled}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    check_output("flush_idle_busy", {31'd0, busy}, 32'd0);

    $display("[TB] late alu completion after flush");
    req_valid = 1'b1;
    req_op    = 3'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid     = 1'b0;
    flush         = 1'b1;
    alu_completed = 1'b1;
    alu_result    = 32'hAAAA_AAAA;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    alu_completed = 1'b0;
    check_output("late_alu_valid", {31'd0, resp_valid}, 32'd0);
    check_output("late_alu_busy", {31'd0, busy}, 32'd0);

    $display("[TB] reset mid-divide");
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_rs1   = 32'd12345;
    req_rs2   = 32'd11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rstn      = 1'b0;
    req_valid = 1'b1;
    req_op    = 3'd0;
    #1;
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_valid", {31'd0, resp_valid}, 32'd0);
    check_output("rst_result", resp_result, 32'd0);
    check_output("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_output("rst_alu_enabled", {31'd0, alu_enabled}, 32'd0);
    @(negedge clk);
    rstn      = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    apply_stimulus(3'd5, 32'd9, 32'd3, 32'd0, 1'b0, res, lat, to);
    check_output("rst_divu_timeout", {31'd0, to}, 32'd0);
    check_output("rst_divu_result", res, 32'd3);

    $display("[TB] random ops");
    for (int i = 0; i < 1000; i++) begin
      op   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      a    = pick_operand();
      b    = pick_operand();
      aluv = $urandom;
      apply_stimulus(op, a, b, aluv, 1'b1, res, lat, to);
      check_output("rand_timeout", {31'd0, to}, 32'd0);
      check_output($sformatf("rand%0d_op%0d_%h_%h_result", i, op, a, b), res, ref_result(op, a, b, aluv));
      check_output($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(op, a, b)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
